multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Control sequencer for the multi-cycle R/I CPU: one shared ALU, register file and memory, stepped over IF/ID/EX/MEM/WB states.
- Replaces the single-cycle combinational translate/control unit.
- Drives PC, IR, register-file and data-RAM write enables, datapath mux selects and ALU_OP.
- Counts retired instructions.
- Sits between the instruction register (opcode/func in) and the datapath muxes and enables (controls out).

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clka  in  1  single system clock, rising edge.
- rsta  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- opa  in  6  IR[31:26] opcode.
- funca  in  6  IR[5:0] function field.
- zfa  in  1  ALU zero flag (beq decision).
- ir_write  out  1  load IR from instruction memory.
- pc_write  out  1  update PC.
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target.
- reg_write  out  1  register-file write enable.
- rd_rt_s  out  1  1 = write address is rt, 0 = rd.
- imm_s  out  1  1 = sign-extend imm, 0 = zero-extend.
- rt_imm_s  out  1  1 = ALU B is imm, 0 = R_Data_B.
- alu_mem_s  out  1  1 = write-back data from memory, 0 = ALU.
- mem_write  out  1  data-RAM write enable.
- alu_op  out  3  ALU operation.
- busy  out  1  1 in any state except IDLE.
- inst_done  out  1  one-cycle pulse in the final state of each instruction.
- illegal  out  1  sticky flag: an undecodable opcode or func was seen.
- inst_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rsta=0, async): state=IDLE, latched class=NOP, inst_cnt=0, illegal=0. All enables=0, pc_src=00, selects=0, alu_op=100.
- States: IDLE, IF, ID, EX, MEM, WB.
- IDLE: stays in IDLE while run=0. Goes to IF when run=1.
- IF: ir_write=1, pc_write=1, pc_src=00, alu_op=ADD. Always goes to ID.
- ID: samples opa/funca and registers class + alu_op + selects.
- ALU-op encoding: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT, 111 SLL.
- R-type (opa=000000) funca decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 000100 SLL.
- I-type opcode decode:
  - 001000 addi: ADD, sign-extend.
  - 001100 andi, 001101 ori, 001110 xori: AND/OR/XOR, zero-extend.
  - 001010 slti: SLT, sign-extend.
  - 100011 lw, 101011 sw: ADD, sign-extend.
  - 000100 beq: SUB, rt_imm_s=0.
  - 000010 j: no ALU use.
- Decode failure: illegal is set (sticky until reset); the instruction retires as NOP from ID.
- Per-class sequences (cycles from IF):
  - R / ALU-I: IF, ID, EX, WB (4). rd_rt_s = 1 for I-type.
  - lw: IF, ID, EX, MEM, WB (5). WB has alu_mem_s=1.
  - sw: IF, ID, EX, MEM (4). mem_write=1 in MEM only.
  - beq: IF, ID, EX (3). In EX, pc_write=zfa, pc_src=01.
  - j: IF, ID (2). In ID, pc_write=1, pc_src=10.
  - NOP / illegal: IF, ID (2).
- Outputs are Moore: a function of state and latched decode only. Only beq's EX pc_write depends on zfa.
- reg_write=1 only in WB. mem_write=1 only in sw MEM. Neither is ever asserted in IF, ID or IDLE.
- Final state of each instruction: inst_done=1 and inst_cnt increments (wraps at 2^CNT_W-1 -> 0).
  - Next state = IF if run=1, else IDLE.
- run dropping mid-instruction: the current instruction completes fully before returning to IDLE.
- Reset mid-instruction: immediate return to IDLE; no partial writes after reset asserts.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode and func constants;
  - ALU_OP codes;
  - pc_src codes;
  - state enum;
  - instruction-class enum (R, ALUI, LW, SW, BEQ, J, NOP).
- Sub-module alu_op_decode: combinational opa/funca -> {class, alu_op, imm_s, rt_imm_s, rd_rt_s, illegal}. The FSM registers its outputs in ID.

Test Plan:
- Reset with run=1 held, then release -> IDLE for 0 cycles, IF next edge; ir_write=1 and pc_write=1 in IF only.
- add (opa=000000, funca=100000) -> 4 cycles; alu_op=100 in EX; reg_write=1, rd_rt_s=0 in WB; inst_done once; inst_cnt 0->1.
- lw then sw (100011, 101011) -> lw 5 cycles with alu_mem_s=1 in WB; sw 4 cycles with mem_write=1 for exactly 1 cycle and reg_write never asserted.
- beq with zfa=1 then zfa=0 -> 3 cycles each; pc_write=1, pc_src=01 only when zfa=1; j -> 2 cycles with pc_src=10.
- Illegal opa=111111 -> illegal=1 and stays 1; instruction retires in 2 cycles; no write enables asserted.
- run dropped during lw MEM -> WB completes, then IDLE with busy=0.
- Reset asserted in the EX of add -> state IDLE, reg_write=0 at once; inst_cnt=0.
- Counter preloaded/run to 0xFFFF plus one more instruction -> inst_cnt=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle R/I CPU control sequencer:
// opcode/func fields, ALU operations, PC sources, FSM states and instruction classes.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000100;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_XOR = 3'b010,
    ALU_NOR = 3'b011,
    ALU_ADD = 3'b100,
    ALU_SUB = 3'b101,
    ALU_SLT = 3'b110,
    ALU_SLL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10
  } pc_src_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IF,
    ST_ID,
    ST_EX,
    ST_MEM,
    ST_WB
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_R,
    CLS_ALUI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J
  } inst_class_t;

  typedef struct packed {
    inst_class_t cls;
    alu_op_t     alu_op;
    logic        imm_s;
    logic        rt_imm_s;
    logic        rd_rt_s;
  } decode_t;

  localparam decode_t DECODE_NOP = '{
    cls: CLS_NOP, alu_op: ALU_ADD, imm_s: 1'b0, rt_imm_s: 1'b0, rd_rt_s: 1'b0
  };

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decode: opcode/func -> class, ALU op and datapath selects.
// Anything not in the supported R/I subset decodes as NOP with illegal raised.
module alu_op_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opa,
  input  logic [5:0] funca,
  output decode_t    dec,
  output logic       illegal
);

  always_comb begin
    dec     = DECODE_NOP;
    illegal = 1'b0;
    case (opa)
      OP_RTYPE: begin
        dec.cls = CLS_R;
        case (funca)
          FN_ADD:  dec.alu_op = ALU_ADD;
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_XOR:  dec.alu_op = ALU_XOR;
          FN_NOR:  dec.alu_op = ALU_NOR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          FN_SLL:  dec.alu_op = ALU_SLL;
          default: begin
            dec.cls = CLS_NOP;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: dec = '{cls: CLS_ALUI, alu_op: ALU_ADD, imm_s: 1'b1, rt_imm_s: 1'b1, rd_rt_s: 1'b1};
      OP_ANDI: dec = '{cls: CLS_ALUI, alu_op: ALU_AND, imm_s: 1'b0, rt_imm_s: 1'b1, rd_rt_s: 1'b1};
      OP_ORI:  dec = '{cls: CLS_ALUI, alu_op: ALU_OR,  imm_s: 1'b0, rt_imm_s: 1'b1, rd_rt_s: 1'b1};
      OP_XORI: dec = '{cls: CLS_ALUI, alu_op: ALU_XOR, imm_s: 1'b0, rt_imm_s: 1'b1, rd_rt_s: 1'b1};
      OP_SLTI: dec = '{cls: CLS_ALUI, alu_op: ALU_SLT, imm_s: 1'b1, rt_imm_s: 1'b1, rd_rt_s: 1'b1};
      OP_LW:   dec = '{cls: CLS_LW,   alu_op: ALU_ADD, imm_s: 1'b1, rt_imm_s: 1'b1, rd_rt_s: 1'b1};
      OP_SW:   dec = '{cls: CLS_SW,   alu_op: ALU_ADD, imm_s: 1'b1, rt_imm_s: 1'b1, rd_rt_s: 1'b0};
      // beq compares two registers; imm_s only matters for the branch-target adder
      OP_BEQ:  dec = '{cls: CLS_BEQ,  alu_op: ALU_SUB, imm_s: 1'b1, rt_imm_s: 1'b0, rd_rt_s: 1'b0};
      OP_J:    dec.cls = CLS_J;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer: steps IF/ID/EX/MEM/WB, drives datapath enables and
// selects from the state plus the decode latched in ID, and counts retired instructions.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clka,
  input  logic             rsta,
  input  logic             run,
  input  logic [5:0]       opa,
  input  logic [5:0]       funca,
  input  logic             zfa,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             rd_rt_s,
  output logic             imm_s,
  output logic             rt_imm_s,
  output logic             alu_mem_s,
  output logic             mem_write,
  output logic [2:0]       alu_op,
  output logic             busy,
  output logic             inst_done,
  output logic             illegal,
  output logic [CNT_W-1:0] inst_cnt
);

  state_t  state;
  decode_t dec_live;
  decode_t dec_q;
  logic    dec_illegal;
  logic    last_state;

  alu_op_decode u_alu_op_decode (
    .opa     (opa),
    .funca   (funca),
    .dec     (dec_live),
    .illegal (dec_illegal)
  );

  // The IR only becomes valid in ID, so j/NOP retirement there uses the live decode.
  assign last_state = ((state == ST_ID)  && ((dec_live.cls == CLS_J) || (dec_live.cls == CLS_NOP)))
                   || ((state == ST_EX)  && (dec_q.cls == CLS_BEQ))
                   || ((state == ST_MEM) && (dec_q.cls == CLS_SW))
                   ||  (state == ST_WB);

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      state    <= ST_IDLE;
      dec_q    <= DECODE_NOP;
      illegal  <= 1'b0;
      inst_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every branch below sees pre-edge state and counts.
      if (state == ST_ID) begin
        dec_q <= dec_live;
        if (dec_illegal) illegal <= 1'b1;
      end

      if (last_state) begin
        inst_cnt <= inst_cnt + CNT_W'(1);
        state    <= run ? ST_IF : ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (run) state <= ST_IF;
          ST_IF:   state <= ST_ID;
          ST_ID:   state <= ST_EX;
          ST_EX:   state <= ((dec_q.cls == CLS_LW) || (dec_q.cls == CLS_SW)) ? ST_MEM : ST_WB;
          ST_MEM:  state <= ST_WB;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_SEQ;
    reg_write = 1'b0;
    mem_write = 1'b0;
    rd_rt_s   = 1'b0;
    imm_s     = 1'b0;
    rt_imm_s  = 1'b0;
    alu_mem_s = 1'b0;
    alu_op    = ALU_ADD;
    case (state)
      ST_IF: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      ST_ID: begin
        if (dec_live.cls == CLS_J) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
        end
      end
      ST_EX, ST_MEM, ST_WB: begin
        alu_op   = dec_q.alu_op;
        imm_s    = dec_q.imm_s;
        rt_imm_s = dec_q.rt_imm_s;
        rd_rt_s  = dec_q.rd_rt_s;
        if (state == ST_EX && dec_q.cls == CLS_BEQ) begin
          pc_write = zfa;
          pc_src   = PC_SRC_BRANCH;
        end
        mem_write = (state == ST_MEM) && (dec_q.cls == CLS_SW);
        reg_write = (state == ST_WB);
        alu_mem_s = (state == ST_WB) && (dec_q.cls == CLS_LW);
      end
      default: ;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign inst_done = last_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a per-instruction phase model built from
// the class timing table, checked every cycle, plus directed and random instruction streams.
module tb_multicycle_control;

  localparam int CNT_W_SMALL = 4;

  localparam int K_R = 0, K_ALUI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_BAD = 6;
  localparam int PH_IDLE = 0, PH_IF = 1, PH_ID = 2, PH_EX = 3, PH_MEM = 4, PH_WB = 5;

  typedef struct {
    int         kind;
    logic [2:0] aop;
    logic       imm;
    logic       rtimm;
  } ref_t;

  logic       clka = 1'b0;
  logic       rsta, run, zfa;
  logic [5:0] opa, funca;

  logic        ir_write, pc_write, reg_write, rd_rt_s, imm_s, rt_imm_s, alu_mem_s, mem_write;
  logic        busy, inst_done, illegal;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op;
  logic [15:0] inst_cnt;

  logic        ir_write_w, pc_write_w, reg_write_w, rd_rt_s_w, imm_s_w, rt_imm_s_w;
  logic        alu_mem_s_w, mem_write_w, busy_w, inst_done_w, illegal_w;
  logic [1:0]  pc_src_w;
  logic [2:0]  alu_op_w;
  logic [CNT_W_SMALL-1:0] inst_cnt_w;

  multicycle_control dut (
    .clka(clka), .rsta(rsta), .run(run), .opa(opa), .funca(funca), .zfa(zfa),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .rd_rt_s(rd_rt_s), .imm_s(imm_s), .rt_imm_s(rt_imm_s), .alu_mem_s(alu_mem_s),
    .mem_write(mem_write), .alu_op(alu_op), .busy(busy), .inst_done(inst_done),
    .illegal(illegal), .inst_cnt(inst_cnt)
  );

  // Narrow counter instance so the wrap to zero is reachable in a short run.
  multicycle_control #(.CNT_W(CNT_W_SMALL)) dut_w (
    .clka(clka), .rsta(rsta), .run(run), .opa(opa), .funca(funca), .zfa(zfa),
    .ir_write(ir_write_w), .pc_write(pc_write_w), .pc_src(pc_src_w), .reg_write(reg_write_w),
    .rd_rt_s(rd_rt_s_w), .imm_s(imm_s_w), .rt_imm_s(rt_imm_s_w), .alu_mem_s(alu_mem_s_w),
    .mem_write(mem_write_w), .alu_op(alu_op_w), .busy(busy_w), .inst_done(inst_done_w),
    .illegal(illegal_w), .inst_cnt(inst_cnt_w)
  );

  always #5 clka = ~clka;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state and the expectation snapshot for the current cycle
  int   model_cnt = 0;
  logic model_ill = 1'b0;
  logic need_kick = 1'b0;
  logic exp_valid = 1'b0;
  ref_t r_idle;

  logic       e_ir_write, e_pc_write, e_reg_write, e_mem_write, e_alu_mem_s, e_done, e_busy;
  logic [1:0] e_pc_src;
  logic [2:0] e_alu_op;
  logic       e_chk_alu, e_chk_rtimm, e_rt_imm_s, e_chk_imm, e_imm_s, e_chk_rd, e_rd_rt_s;
  logic       e_illegal;
  int         e_cnt;

  function automatic ref_t ref_decode(input logic [5:0] op, input logic [5:0] fn);
    ref_t r;
    r = '{kind: K_BAD, aop: 3'b100, imm: 1'b0, rtimm: 1'b0};
    case (op)
      6'b000000: begin
        r.kind = K_R;
        case (fn)
          6'b100000: r.aop = 3'b100;
          6'b100010: r.aop = 3'b101;
          6'b100100: r.aop = 3'b000;
          6'b100101: r.aop = 3'b001;
          6'b100110: r.aop = 3'b010;
          6'b100111: r.aop = 3'b011;
          6'b101010: r.aop = 3'b110;
          6'b000100: r.aop = 3'b111;
          default:   r.kind = K_BAD;
        endcase
      end
      6'b001000: r = '{kind: K_ALUI, aop: 3'b100, imm: 1'b1, rtimm: 1'b1};
      6'b001100: r = '{kind: K_ALUI, aop: 3'b000, imm: 1'b0, rtimm: 1'b1};
      6'b001101: r = '{kind: K_ALUI, aop: 3'b001, imm: 1'b0, rtimm: 1'b1};
      6'b001110: r = '{kind: K_ALUI, aop: 3'b010, imm: 1'b0, rtimm: 1'b1};
      6'b001010: r = '{kind: K_ALUI, aop: 3'b110, imm: 1'b1, rtimm: 1'b1};
      6'b100011: r = '{kind: K_LW,   aop: 3'b100, imm: 1'b1, rtimm: 1'b1};
      6'b101011: r = '{kind: K_SW,   aop: 3'b100, imm: 1'b1, rtimm: 1'b1};
      6'b000100: r = '{kind: K_BEQ,  aop: 3'b101, imm: 1'b1, rtimm: 1'b0};
      6'b000010: r.kind = K_J;
      default: ;
    endcase
    return r;
  endfunction

  task automatic set_expect(input int ph, input ref_t r, input logic zf);
    e_ir_write = 0; e_pc_write = 0; e_pc_src = 2'b00; e_reg_write = 0; e_mem_write = 0;
    e_alu_mem_s = 0; e_done = 0; e_alu_op = 3'b100; e_chk_alu = 0;
    e_chk_rtimm = 0; e_rt_imm_s = 0; e_chk_imm = 0; e_imm_s = 0; e_chk_rd = 0; e_rd_rt_s = 0;
    e_busy = (ph != PH_IDLE);
    e_cnt = model_cnt;
    e_illegal = model_ill;
    case (ph)
      PH_IDLE: e_chk_alu = 1;
      PH_IF: begin
        e_ir_write = 1; e_pc_write = 1; e_chk_alu = 1;
      end
      PH_ID: begin
        if (r.kind == K_J) begin
          e_pc_write = 1; e_pc_src = 2'b10;
        end
        e_done = (r.kind == K_J) || (r.kind == K_BAD);
      end
      PH_EX: begin
        e_chk_alu = 1; e_alu_op = r.aop;
        e_chk_rtimm = 1; e_rt_imm_s = r.rtimm;
        e_chk_imm = (r.kind == K_ALUI) || (r.kind == K_LW) || (r.kind == K_SW);
        e_imm_s = r.imm;
        if (r.kind == K_BEQ) begin
          e_pc_write = zf; e_pc_src = 2'b01; e_done = 1;
        end
      end
      PH_MEM: begin
        e_mem_write = (r.kind == K_SW);
        e_done = (r.kind == K_SW);
      end
      PH_WB: begin
        e_reg_write = 1; e_chk_rd = 1; e_rd_rt_s = (r.kind != K_R);
        e_alu_mem_s = (r.kind == K_LW); e_done = 1;
      end
      default: ;
    endcase
  endtask

  // One cycle in which the DUT must be in phase ph; inputs for that cycle are driven here.
  task automatic step(input int ph, input ref_t r, input logic zf, input logic run_v);
    @(posedge clka);
    #1;
    run = run_v;
    zfa = (ph == PH_EX) ? zf : 1'($urandom_range(0, 1));
    set_expect(ph, r, zf);
    exp_valid = 1'b1;
  endtask

  task automatic idle_steps(input int n);
    repeat (n) step(PH_IDLE, r_idle, 1'b0, 1'b0);
  endtask

  // One whole instruction; run falls to 0 from phase index drop_at onwards.
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic zf, input int drop_at);
    ref_t r;
    int   ph_q[$];
    r = ref_decode(op, fn);
    ph_q = {PH_IF, PH_ID};
    case (r.kind)
      K_R, K_ALUI: ph_q = {ph_q, PH_EX, PH_WB};
      K_LW:        ph_q = {ph_q, PH_EX, PH_MEM, PH_WB};
      K_SW:        ph_q = {ph_q, PH_EX, PH_MEM};
      K_BEQ:       ph_q = {ph_q, PH_EX};
      default: ;
    endcase
    if (need_kick) step(PH_IDLE, r_idle, 1'b0, 1'b1);
    for (int i = 0; i < ph_q.size(); i++) begin
      step(ph_q[i], r, zf, (i < drop_at));
      if (i == 0) begin
        opa = op;
        funca = fn;
      end
      if (ph_q[i] == PH_ID && r.kind == K_BAD) model_ill = 1'b1;
    end
    model_cnt++;
    need_kick = (drop_at < ph_q.size());
  endtask

  // Single compare process: every cycle with a valid expectation
  always @(negedge clka) begin
    if (exp_valid) begin
      check("ir_write",  32'(ir_write),  32'(e_ir_write));
      check("pc_write",  32'(pc_write),  32'(e_pc_write));
      check("pc_src",    32'(pc_src),    32'(e_pc_src));
      check("reg_write", 32'(reg_write), 32'(e_reg_write));
      check("mem_write", 32'(mem_write), 32'(e_mem_write));
      check("alu_mem_s", 32'(alu_mem_s), 32'(e_alu_mem_s));
      check("busy",      32'(busy),      32'(e_busy));
      check("inst_done", 32'(inst_done), 32'(e_done));
      check("illegal",   32'(illegal),   32'(e_illegal));
      check("inst_cnt",  32'(inst_cnt),  32'(e_cnt % 65536));
      if (e_chk_alu)   check("alu_op",   32'(alu_op),   32'(e_alu_op));
      if (e_chk_rtimm) check("rt_imm_s", 32'(rt_imm_s), 32'(e_rt_imm_s));
      if (e_chk_imm)   check("imm_s",    32'(imm_s),    32'(e_imm_s));
      if (e_chk_rd)    check("rd_rt_s",  32'(rd_rt_s),  32'(e_rd_rt_s));
      check("w_ctrl", 32'({ir_write_w, pc_write_w, pc_src_w, reg_write_w, mem_write_w,
                           alu_mem_s_w, busy_w, inst_done_w, illegal_w}),
                      32'({e_ir_write, e_pc_write, e_pc_src, e_reg_write, e_mem_write,
                           e_alu_mem_s, e_busy, e_done, e_illegal}));
      check("w_inst_cnt", 32'(inst_cnt_w), 32'(e_cnt % (1 << CNT_W_SMALL)));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [5:0] r_funcs[8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                             6'b100110, 6'b100111, 6'b101010, 6'b000100};
  logic [5:0] i_ops[9]   = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010,
                             6'b100011, 6'b101011, 6'b000100, 6'b000010};
  logic [5:0] bad_ops[4] = '{6'b111111, 6'b000001, 6'b010000, 6'b100000};
  logic [5:0] bad_fns[3] = '{6'b000000, 6'b111111, 6'b100001};
  logic [5:0] rop, rfn;
  int         rk, rdrop;

  initial begin
    r_idle = '{kind: K_BAD, aop: 3'b100, imm: 1'b0, rtimm: 1'b0};
    rsta = 1'b0; run = 1'b1; opa = '0; funca = '0; zfa = 1'b0;
    set_expect(PH_IDLE, r_idle, 1'b0);
    exp_valid = 1'b1;
    repeat (3) @(posedge clka);
    #1 rsta = 1'b1;

    // add, run dropped at its final state
    instr(6'b000000, 6'b100000, 1'b0, 3);
    idle_steps(1);
    check("add_cnt_literal", 32'(inst_cnt), 32'd1);
    check("add_idle_busy", 32'(busy), 32'd0);

    // lw, sw, then lw with run dropped in MEM
    instr(6'b100011, 6'b000000, 1'b0, 99);
    instr(6'b101011, 6'b000000, 1'b0, 99);
    instr(6'b100011, 6'b000000, 1'b0, 3);
    idle_steps(2);
    check("lw_drop_busy", 32'(busy), 32'd0);
    check("lw_drop_cnt_literal", 32'(inst_cnt), 32'd4);

    // beq taken / not taken, j, illegal opcode
    instr(6'b000100, 6'b000000, 1'b1, 99);
    instr(6'b000100, 6'b000000, 1'b0, 99);
    instr(6'b000010, 6'b000000, 1'b0, 99);
    instr(6'b111111, 6'b000000, 1'b0, 1);
    idle_steps(1);
    check("illegal_literal", 32'(illegal), 32'd1);
    check("illegal_cnt_literal", 32'(inst_cnt), 32'd8);

    for (int n = 0; n < 60; n++) begin
      rk = $urandom_range(0, 18);
      rfn = 6'($urandom_range(0, 63));
      if (rk < 8) begin
        rop = 6'b000000; rfn = r_funcs[rk];
      end else if (rk < 17) begin
        rop = i_ops[rk-8];
      end else if (rk == 17) begin
        rop = bad_ops[$urandom_range(0, 3)];
      end else begin
        rop = 6'b000000; rfn = bad_fns[$urandom_range(0, 2)];
      end
      rdrop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : 99;
      instr(rop, rfn, 1'($urandom_range(0, 1)), rdrop);
      if (need_kick) idle_steps($urandom_range(0, 2));
    end

    // Reset asserted while add is in EX
    if (need_kick) step(PH_IDLE, r_idle, 1'b0, 1'b1);
    step(PH_IF, ref_decode(6'b000000, 6'b100000), 1'b0, 1'b1);
    opa = 6'b000000; funca = 6'b100000;
    step(PH_ID, ref_decode(6'b000000, 6'b100000), 1'b0, 1'b1);
    step(PH_EX, ref_decode(6'b000000, 6'b100000), 1'b0, 1'b1);
    exp_valid = 1'b0;
    #2 rsta = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_reg_write", 32'(reg_write), 32'd0);
    check("rst_mid_inst_cnt", 32'(inst_cnt), 32'd0);
    check("rst_mid_illegal", 32'(illegal), 32'd0);
    check("rst_mid_alu_op", 32'(alu_op), 32'd4);
    @(negedge clka);
    run = 1'b0;
    rsta = 1'b1;
    model_cnt = 0; model_ill = 1'b0; need_kick = 1'b1;
    idle_steps(2);

    // 16 jumps: narrow counter wraps to zero
    for (int n = 0; n < 16; n++) instr(6'b000010, 6'b000000, 1'b0, (n == 15) ? 1 : 99);
    idle_steps(1);
    check("wrap_small_literal", 32'(inst_cnt_w), 32'd0);
    check("wrap_full_literal", 32'(inst_cnt), 32'd16);

    exp_valid = 1'b0;
    @(posedge clka);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
